// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states and
// the registered request control fields.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_RMW_RD = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd4;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } req_ctl_t;

  // Byte and half stores cannot be written directly: the memory has no byte enables.
  function automatic logic size_is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane steering for the data-memory initiator: merges store data into the
// read word for read-modify-write, and extracts/extends load data.
module mem_lane_mux
  import mem_access_pkg::*;
#(
  parameter int BYTE_SIZE = 4
) (
  input  logic [1:0]             size,
  input  logic                   uns,
  input  logic [8*BYTE_SIZE-1:0] rd,
  input  logic [8*BYTE_SIZE-1:0] wdata,
  output logic [8*BYTE_SIZE-1:0] merged,
  output logic [8*BYTE_SIZE-1:0] load_data
);

  localparam int DW = 8 * BYTE_SIZE;

  logic sign_b;
  logic sign_h;

  // The sign bit is forced low for unsigned loads so one replication covers both.
  always_comb begin
    sign_b    = rd[7] & ~uns;
    sign_h    = rd[15] & ~uns;
    merged    = wdata;
    load_data = rd;
    case (size)
      SIZE_BYTE: begin
        merged    = {rd[DW-1:8], wdata[7:0]};
        load_data = {{(DW-8){sign_b}}, rd[7:0]};
      end
      SIZE_HALF: begin
        merged    = {rd[DW-1:16], wdata[15:0]};
        load_data = {{(DW-16){sign_h}}, rd[15:0]};
      end
      default: begin
        merged    = wdata;
        load_data = rd;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Initiator for the byte-addressed data memory: byte/half/word loads and stores,
// sub-word stores via read-modify-write. Optional MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned half/word.
module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 516
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_uns,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [8*BYTE_SIZE-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*BYTE_SIZE-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [8*BYTE_SIZE-1:0] mem_wd,
  input  logic [8*BYTE_SIZE-1:0] mem_rd
);

  localparam int DW = 8 * BYTE_SIZE;
  // Every access spans ADDR..ADDR+BYTE_SIZE-1, so the last legal start is one word below the end.
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_BYTES - BYTE_SIZE);

  logic [STATE_W-1:0]    state_q, state_d;
  req_ctl_t              ctl_q, ctl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;

  logic                  misalign;
  logic                  req_err;
  logic [DW-1:0]         merged;
  logic [DW-1:0]         load_data;

  mem_lane_mux #(
    .BYTE_SIZE (BYTE_SIZE)
  ) u_lane_mux (
    .size      (ctl_q.size),
    .uns       (ctl_q.uns),
    .rd        (mem_rd),
    .wdata     (wdata_q),
    .merged    (merged),
    .load_data (load_data)
  );

  // Request legality, evaluated on the live request at the accept cycle.
  always_comb begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign = ((req_size == SIZE_HALF) && (req_addr[0] != 1'b0)) ||
               ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = (req_size == SIZE_RSVD) || (req_addr > MAX_ADDR) || misalign;
  end

  // FSM next state and register updates.
  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ctl_d   = '{we: req_we, size: req_size, uns: req_uns};
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (size_is_sub_word(req_size)) begin
            state_d = ST_RMW_RD;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RMW_RD: begin
        // The merged word replaces the store data so WRITE drives one source.
        wdata_d = merged;
        state_d = ST_WRITE;
      end
      ST_LOAD, ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ctl_q.we ? '0 : load_data;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = ((state_q == ST_LOAD) || (state_q == ST_RMW_RD) || (state_q == ST_WRITE))
                     ? addr_q : '0;
  assign mem_wd    = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed self-checking bench for mem_access_initiator with a 516-byte
// combinational-read memory model attached to the memory port.
module tb_mem_access_initiator;

  localparam int MEMB = 516;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_R = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [7:0]  mem [0:MEMB-1];
  int          n_checks = 0;
  int          n_fail = 0;

  int          lat, wes;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  mem_access_initiator #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .MEM_BYTES(MEMB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_uns   (req_uns),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // Little-endian memory: byte at ADDR lands in the low lane.
  always_comb begin
    mem_rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (mem_addr + 32'(i) < 32'(MEMB)) mem_rd[8*i +: 8] = mem[mem_addr + 32'(i)];
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_addr + 32'(i) < 32'(MEMB)) mem[mem_addr + 32'(i)] <= mem_wd[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] word_at(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response transaction; starts and ends at a negedge.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output int l, output logic [31:0] rdata, output logic err, output int nwe);
    nwe = 0;
    check("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 8) begin
      if (mem_we) nwe++;
      @(negedge clk);
      l++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) word store then word load
    txn(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 0, lat, rd, er, wes);
    check("c1_st_lat", 32'(lat), 32'd2);
    check("c1_st_err", 32'(er), 32'd0);
    check("c1_st_rdata", rd, 32'd0);
    check("c1_st_we", 32'(wes), 32'd1);
    check("c1_mem", word_at(32'h10), 32'hDEADBEEF);
    txn(1'b0, SZ_W, 1'b0, 32'h10, 32'd0, 0, lat, rd, er, wes);
    check("c1_ld_lat", 32'(lat), 32'd2);
    check("c1_ld_data", rd, 32'hDEADBEEF);
    check("c1_ld_err", 32'(er), 32'd0);
    check("c1_ld_we", 32'(wes), 32'd0);

    // 2) byte store via read-modify-write
    txn(1'b1, SZ_B, 1'b0, 32'h11, 32'hFFFFFF7F, 0, lat, rd, er, wes);
    check("c2_st_lat", 32'(lat), 32'd3);
    check("c2_st_we", 32'(wes), 32'd1);
    check("c2_st_err", 32'(er), 32'd0);
    txn(1'b0, SZ_W, 1'b0, 32'h10, 32'd0, 0, lat, rd, er, wes);
    check("c2_ld_data", rd, 32'hDEAD7FEF);

    // 3) sub-word loads with extension
    txn(1'b0, SZ_B, 1'b0, 32'h13, 32'd0, 0, lat, rd, er, wes);
    check("c3_lb_s", rd, 32'hFFFFFFDE);
    txn(1'b0, SZ_B, 1'b1, 32'h13, 32'd0, 0, lat, rd, er, wes);
    check("c3_lb_u", rd, 32'h000000DE);
    txn(1'b0, SZ_H, 1'b0, 32'h12, 32'd0, 0, lat, rd, er, wes);
    check("c3_lh_s", rd, 32'hFFFFDEAD);
    txn(1'b0, SZ_H, 1'b1, 32'h12, 32'd0, 0, lat, rd, er, wes);
    check("c3_lh_u", rd, 32'h0000DEAD);

    // 4) range boundary and reserved size
    txn(1'b1, SZ_W, 1'b0, 32'd512, 32'hCAFEF00D, 0, lat, rd, er, wes);
    check("c4_512_err", 32'(er), 32'd0);
    check("c4_512_we", 32'(wes), 32'd1);
    check("c4_512_mem", word_at(512), 32'hCAFEF00D);
    txn(1'b1, SZ_W, 1'b0, 32'd513, 32'h12345678, 0, lat, rd, er, wes);
    check("c4_513_err", 32'(er), 32'd1);
    check("c4_513_we", 32'(wes), 32'd0);
    check("c4_513_lat", 32'(lat), 32'd1);
    check("c4_513_mem", word_at(512), 32'hCAFEF00D);
    txn(1'b0, SZ_R, 1'b0, 32'h10, 32'd0, 0, lat, rd, er, wes);
    check("c4_rsvd_err", 32'(er), 32'd1);
    check("c4_rsvd_lat", 32'(lat), 32'd1);
    check("c4_rsvd_rdata", rd, 32'd0);

    // 5) response backpressure, then back-to-back
    txn(1'b0, SZ_W, 1'b0, 32'h10, 32'd0, 5, lat, rd, er, wes);
    check("c5_data", rd, 32'hDEAD7FEF);
    check("c5_valid_low", 32'(rsp_valid), 32'd0);
    check("c5_ready_back", 32'(req_ready), 32'd1);
    txn(1'b0, SZ_B, 1'b1, 32'h10, 32'd0, 0, lat, rd, er, wes);
    check("c5_b2b_data", rd, 32'h000000EF);
    check("c5_b2b_lat", 32'(lat), 32'd2);

    // 6) reset during RMW_RD of a byte store
    txn(1'b1, SZ_W, 1'b0, 32'h20, 32'h55667788, 0, lat, rd, er, wes);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_uns = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("c6_in_rmw_addr", mem_addr, 32'h20);
    rst_n = 1'b0;
    #1;
    check("c6_rst_we", 32'(mem_we), 32'd0);
    check("c6_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wes = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_we) wes++;
    end
    check("c6_no_we", 32'(wes), 32'd0);
    check("c6_mem", word_at(32'h20), 32'h55667788);
    check("c6_valid", 32'(rsp_valid), 32'd0);
    check("c6_ready", 32'(req_ready), 32'd1);

    // Misaligned word store
    txn(1'b1, SZ_W, 1'b0, 32'h11, 32'h11223344, 0, lat, rd, er, wes);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("al_err", 32'(er), 32'd1);
    check("al_we", 32'(wes), 32'd0);
    check("al_mem", word_at(32'h10), 32'hDEAD7FEF);
`else
    check("al_err", 32'(er), 32'd0);
    check("al_we", 32'(wes), 32'd1);
    check("al_mem", word_at(32'h11), 32'h11223344);
    txn(1'b0, SZ_W, 1'b0, 32'h11, 32'd0, 0, lat, rd, er, wes);
    check("al_ld", rd, 32'h11223344);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
